// File: rtl/player_input_capture_pkg.sv
// Shared colour codes, capture FSM states and the one-hot -> colour encoder.
package player_input_capture_pkg;

  localparam logic [1:0] COL_0 = 2'b00;
  localparam logic [1:0] COL_1 = 2'b01;
  localparam logic [1:0] COL_2 = 2'b10;
  localparam logic [1:0] COL_3 = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_PRESS,
    ST_DB_PRESS,
    ST_WAIT_RELEASE,
    ST_DB_RELEASE,
    ST_DONE,
    ST_FAULT
  } state_t;

  function automatic logic is_one_hot(input logic [3:0] v);
    return (v != 4'b0000) && ((v & (v - 4'b0001)) == 4'b0000);
  endfunction

  // Non-one-hot vectors never reach the encoder on an accepted press.
  function automatic logic [1:0] encode_colour(input logic [3:0] v);
    case (v)
      4'b0010: return COL_1;
      4'b0100: return COL_2;
      4'b1000: return COL_3;
      default: return COL_0;
    endcase
  endfunction

endpackage

// File: rtl/player_input_capture_debounce.sv
// Button synchroniser plus stability tracker. The tracked value doubles as the
// press candidate; i_clr restarts the stability count from the current sample.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int W               = 4
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_clr,
  input  logic [W-1:0] i_raw,
  output logic [W-1:0] o_sb,
  output logic [W-1:0] o_stable_value,
  output logic         o_stable,
  output logic         o_changed
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  // Latch sample plus (CNT_MAX+1) matching samples gives DEBOUNCE_CYCLES total.
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 2);

  logic [W-1:0]  r_meta, r_sync, r_val;
  logic [CW-1:0] r_cnt;

  // Two-flop synchroniser for the asynchronous button pins.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_raw;
      r_sync <= r_meta;
    end
  end

  // Track the last value and count consecutive matching samples (saturating).
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_val <= '0;
      r_cnt <= '0;
    end else if (i_clr || (r_sync != r_val)) begin
      r_val <= r_sync;
      r_cnt <= '0;
    end else if (r_cnt != CNT_MAX) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_sb           = r_sync;
  assign o_stable_value = r_val;
  assign o_changed      = (r_sync != r_val);
  assign o_stable       = !o_changed && (r_cnt == CNT_MAX);

endmodule

// File: rtl/player_input_capture.sv
// Player button capture: debounces presses, packs accepted colours into a
// sequence word and reports complete / timeout / invalid-press outcomes.
module player_input_capture
  import player_input_capture_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int TIMEOUT_CYCLES  = 1024,
  parameter int MAX_LEN         = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_en,
  input  logic [3:0]           i_buttons,
  input  logic [3:0]           i_sequence_len,
  output logic [2*MAX_LEN-1:0] o_seq_out,
  output logic [4:0]           o_entry_count,
  output logic                 o_press_pulse,
  output logic [1:0]           o_press_colour,
  output logic                 o_busy,
  output logic                 o_complete,
  output logic                 o_timeout,
  output logic                 o_invalid
);

  localparam int             TW       = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0]  TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [4:0]     CNT_FULL = 5'(MAX_LEN);

  state_t               r_state, w_next;
  logic [TW-1:0]        r_to;
  logic [2*MAX_LEN-1:0] r_seq;
  logic [4:0]           r_count;
  logic                 r_pulse, r_complete, r_timeout, r_invalid;
  logic [1:0]           r_colour;

  logic [3:0] w_sb, w_sv;
  logic       w_stable, w_changed;
  logic       w_db_clr, w_clear, w_accept, w_to_inc;
  logic       w_set_complete, w_set_timeout, w_set_invalid;
  logic [4:0] w_target;

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .W              (4)
  ) u_db (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_clr         (w_db_clr),
    .i_raw         (i_buttons),
    .o_sb          (w_sb),
    .o_stable_value(w_sv),
    .o_stable      (w_stable),
    .o_changed     (w_changed)
  );

  assign w_target = {1'b0, i_sequence_len} + 5'd1;

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // Next-state and control strobes; en low overrides everything.
  always_comb begin
    w_next         = r_state;
    w_db_clr       = 1'b0;
    w_clear        = 1'b0;
    w_accept       = 1'b0;
    w_to_inc       = 1'b0;
    w_set_complete = 1'b0;
    w_set_timeout  = 1'b0;
    w_set_invalid  = 1'b0;
    if (!i_en) begin
      w_next  = ST_IDLE;
      w_clear = 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_next  = ST_WAIT_PRESS;
          w_clear = 1'b1;
        end
        ST_WAIT_PRESS: begin
          if (r_to == TO_LAST) begin
            w_next        = ST_FAULT;
            w_set_timeout = 1'b1;
          end else begin
            w_to_inc = 1'b1;
            if (w_sb != 4'b0000) begin
              w_db_clr = 1'b1;
              w_next   = ST_DB_PRESS;
            end
          end
        end
        ST_DB_PRESS: begin
          if (w_changed) begin
            w_next = ST_WAIT_PRESS;
          end else if (w_stable) begin
            if (is_one_hot(w_sv)) begin
              w_accept = (r_count != CNT_FULL);
              w_next   = ST_WAIT_RELEASE;
            end else begin
              w_set_invalid = 1'b1;
              w_next        = ST_FAULT;
            end
          end
        end
        ST_WAIT_RELEASE: begin
          if (w_sb == 4'b0000) begin
            w_db_clr = 1'b1;
            w_next   = ST_DB_RELEASE;
          end
        end
        ST_DB_RELEASE: begin
          if (w_changed) begin
            w_next = ST_WAIT_RELEASE;
          end else if (w_stable) begin
            if (r_count == w_target) begin
              w_set_complete = 1'b1;
              w_next         = ST_DONE;
            end else begin
              w_next = ST_WAIT_PRESS;
            end
          end
        end
        ST_DONE, ST_FAULT: w_next = r_state;
        default:           w_next = ST_IDLE;
      endcase
    end
  end

  // Idle-wait timer: runs while waiting for a press, cleared by each accept.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                    r_to <= '0;
    else if (w_clear || w_accept) r_to <= '0;
    else if (w_to_inc)            r_to <= r_to + 1'b1;
  end

  // Sequence packing, press strobe and sticky outcome flags.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_seq      <= '0;
      r_count    <= '0;
      r_pulse    <= 1'b0;
      r_colour   <= COL_0;
      r_complete <= 1'b0;
      r_timeout  <= 1'b0;
      r_invalid  <= 1'b0;
    end else if (w_clear) begin
      r_seq      <= '0;
      r_count    <= '0;
      r_pulse    <= 1'b0;
      r_colour   <= COL_0;
      r_complete <= 1'b0;
      r_timeout  <= 1'b0;
      r_invalid  <= 1'b0;
    end else begin
      r_pulse <= w_accept;
      if (w_accept) begin
        r_seq[{r_count[3:0], 1'b0} +: 2] <= encode_colour(w_sv);
        r_count  <= r_count + 5'd1;
        r_colour <= encode_colour(w_sv);
      end
      if (w_set_complete) r_complete <= 1'b1;
      if (w_set_timeout)  r_timeout  <= 1'b1;
      if (w_set_invalid)  r_invalid  <= 1'b1;
    end
  end

  assign o_seq_out      = r_seq;
  assign o_entry_count  = r_count;
  assign o_press_pulse  = r_pulse;
  assign o_press_colour = r_colour;
  assign o_complete     = r_complete;
  assign o_timeout      = r_timeout;
  assign o_invalid      = r_invalid;
  assign o_busy         = (r_state != ST_IDLE) && (r_state != ST_DONE) &&
                          (r_state != ST_FAULT);

endmodule

// File: tb/tb_player_input_capture.sv
// Directed bench: expected press colours are queued as stimulus is driven and
// matched against the observed press strobes; final state checked per phase.
module tb_player_input_capture;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [3:0]  buttons;
  logic [3:0]  seq_len;
  logic [31:0] seq_out;
  logic [4:0]  entry_count;
  logic        press_pulse;
  logic [1:0]  press_colour;
  logic        busy, complete, timeout, invalid;

  int n_asserts = 0;
  int n_fail    = 0;

  logic [1:0] exp_q[$];
  logic [1:0] obs [0:255];
  int         obs_wr = 0;
  int         rd     = 0;

  player_input_capture #(
    .DEBOUNCE_CYCLES(4),
    .TIMEOUT_CYCLES (64),
    .MAX_LEN        (16)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_en          (en),
    .i_buttons     (buttons),
    .i_sequence_len(seq_len),
    .o_seq_out     (seq_out),
    .o_entry_count (entry_count),
    .o_press_pulse (press_pulse),
    .o_press_colour(press_colour),
    .o_busy        (busy),
    .o_complete    (complete),
    .o_timeout     (timeout),
    .o_invalid     (invalid)
  );

  always #5 clk = ~clk;

  // Record every press strobe seen by the DUT.
  always @(negedge clk) begin
    if (press_pulse && obs_wr < 256) begin
      obs[obs_wr] = press_colour;
      obs_wr      = obs_wr + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_asserts++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [3:0] b, input int hold, input int rel);
    buttons = b;
    cyc(hold);
    buttons = 4'b0000;
    cyc(rel);
  endtask

  // Match observed strobes against queued expectations; leftovers on either side fail.
  task automatic drain(input string tag);
    logic [1:0] e;
    while (rd < obs_wr) begin
      if (exp_q.size() == 0) begin
        chk({tag, "_extra_pulse"}, {30'd0, obs[rd]}, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk({tag, "_pulse_colour"}, {30'd0, obs[rd]}, {30'd0, e});
      end
      rd++;
    end
    chk({tag, "_missing_pulses"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic restart(input logic [3:0] len);
    en = 1'b0;
    cyc(1);
    seq_len = len;
    en = 1'b1;
    cyc(1);
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; buttons = 4'b0000; seq_len = 4'd2;
    cyc(3);
    // Reset state
    chk("rst_seq", seq_out, 0);
    chk("rst_cnt", {27'd0, entry_count}, 0);
    chk("rst_flags", {26'd0, press_pulse, press_colour, busy, complete, timeout, invalid}, 0);
    rst = 1'b0;
    cyc(2);

    // 1: three clean presses, sequence_len=2
    exp_q.push_back(2'b01); press(4'b0010, 10, 10);
    exp_q.push_back(2'b11); press(4'b1000, 10, 10);
    chk("t1_busy_mid", {31'd0, busy}, 1);
    chk("t1_not_done", {31'd0, complete}, 0);
    exp_q.push_back(2'b00); press(4'b0001, 10, 10);
    chk("t1_seq", seq_out, 32'h0000_000D);
    chk("t1_cnt", {27'd0, entry_count}, 3);
    chk("t1_flags", {28'd0, busy, complete, timeout, invalid}, 4'b0100);
    drain("t1");
    // Activity after DONE is ignored
    press(4'b0100, 10, 10);
    chk("t1_hold_cnt", {27'd0, entry_count}, 3);
    drain("t1_after");

    // 2: glitchy bit2 press, single accept
    restart(4'd0);
    buttons = 4'b0100; cyc(2);
    buttons = 4'b0000; cyc(1);
    buttons = 4'b0100; cyc(2);
    buttons = 4'b0000; cyc(1);
    chk("t2_no_early", {27'd0, entry_count}, 0);
    exp_q.push_back(2'b10); press(4'b0100, 10, 10);
    chk("t2_colour", {30'd0, press_colour}, 2'b10);
    chk("t2_seq", seq_out, 32'h0000_0002);
    chk("t2_complete", {31'd0, complete}, 1);
    drain("t2");

    // 3: timeout with no buttons
    restart(4'd0);
    cyc(58);
    chk("t3_pre_timeout", {30'd0, busy, timeout}, 2'b10);
    begin
      int k = 0;
      while (!timeout && k < 40) begin cyc(1); k++; end
    end
    chk("t3_timeout", {31'd0, timeout}, 1);
    chk("t3_others", {29'd0, complete, invalid, busy}, 0);
    chk("t3_cnt", {27'd0, entry_count}, 0);
    drain("t3");

    // 4: illegal two-button press
    restart(4'd0);
    press(4'b0101, 10, 10);
    chk("t4_invalid", {31'd0, invalid}, 1);
    chk("t4_others", {29'd0, complete, timeout, busy}, 0);
    chk("t4_seq", seq_out, 0);
    press(4'b0001, 10, 10);
    chk("t4_fault_hold", {26'd0, entry_count, invalid}, 6'b000001);
    drain("t4");

    // 5: abort after two entries, then clean restart
    restart(4'd3);
    exp_q.push_back(2'b00); press(4'b0001, 10, 10);
    exp_q.push_back(2'b01); press(4'b0010, 10, 10);
    chk("t5_mid_cnt", {27'd0, entry_count}, 2);
    drain("t5a");
    en = 1'b0; cyc(1);
    chk("t5_abort_seq", seq_out, 0);
    chk("t5_abort_state", {25'd0, entry_count, press_colour}, 0);
    chk("t5_abort_flags", {28'd0, busy, complete, timeout, invalid}, 0);
    en = 1'b1; cyc(1);
    exp_q.push_back(2'b10); press(4'b0100, 10, 10);
    exp_q.push_back(2'b11); press(4'b1000, 10, 10);
    exp_q.push_back(2'b01); press(4'b0010, 10, 10);
    exp_q.push_back(2'b00); press(4'b0001, 10, 10);
    chk("t5_seq", seq_out, 32'h0000_001E);
    chk("t5_done", {26'd0, entry_count, complete}, {5'd4, 1'b1});
    drain("t5b");

    // 6: full 16-entry sequence
    restart(4'd15);
    for (int i = 0; i < 16; i++) begin
      if (i % 2 == 0) begin exp_q.push_back(2'b11); press(4'b1000, 10, 10); end
      else            begin exp_q.push_back(2'b00); press(4'b0001, 10, 10); end
    end
    chk("t6_seq", seq_out, 32'h3333_3333);
    chk("t6_cnt", {27'd0, entry_count}, 16);
    chk("t6_complete", {28'd0, busy, complete, timeout, invalid}, 4'b0100);
    press(4'b1000, 10, 10);
    chk("t6_no_wrap", {27'd0, entry_count}, 16);
    drain("t6");

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
